// File: rtl/wb_dbus_arbiter.sv
// rtl/wb_dbus_arbiter.sv - two-master round-robin Wishbone dbus arbiter, one transaction per grant
// Optional slave-ack watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_dbus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat,
  input  logic [3:0]    m0_sel,
  input  logic          m0_we,
  input  logic          m0_cyc,
  output logic [DW-1:0] m0_rdt,
  output logic          m0_ack,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat,
  input  logic [3:0]    m1_sel,
  input  logic          m1_we,
  input  logic          m1_cyc,
  output logic [DW-1:0] m1_rdt,
  output logic          m1_ack,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat,
  output logic [3:0]    s_sel,
  output logic          s_we,
  output logic          s_cyc,
  input  logic [DW-1:0] s_rdt,
  input  logic          s_ack,
  output logic          owner,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, REL} state_t;

  // An out-of-range TIMEOUT holds err high so a bad build is visible on the bus.
  localparam bit TMO_CFG_OK = (TIMEOUT >= 1) && (TIMEOUT <= 255);

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          w_last_nxt;
  logic          r_owner;
  logic          w_owner_nxt;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_cyc_own;
  logic          w_tmo;
  logic          w_ack_own;
  logic [DW-1:0] w_rdt_own;

  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_cyc_own = w_gnt1 ? m1_cyc : m0_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

  logic [7:0] r_timer;

  // r_timer counts completed ack-less grant cycles, so the current one is r_timer+1.
  assign w_tmo = (w_gnt0 | w_gnt1) & w_cyc_own & ~s_ack &
                 (({1'b0, r_timer} + 9'd1) == TMO_LIMIT);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_timer <= 8'd0;
    end else if (r_state == IDLE) begin
      r_timer <= 8'd0;
    end else if ((w_gnt0 | w_gnt1) & ~s_ack) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  assign err = w_tmo | ~TMO_CFG_OK;
`else
  assign w_tmo = 1'b0;
  assign err   = ~TMO_CFG_OK;
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        // On contention the master that did not win last time is served.
        if (m0_cyc && (!m1_cyc || r_last)) begin
          w_next      = GNT0;
          w_owner_nxt = 1'b0;
        end else if (m1_cyc) begin
          w_next      = GNT1;
          w_owner_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (s_ack || w_tmo) begin
          w_next     = REL;
          w_last_nxt = w_gnt1;
        end else if (!w_cyc_own) begin
          w_next     = IDLE;
          w_last_nxt = w_gnt1;
        end
      end
      REL:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request path follows m0 whenever m1 does not hold the grant.
  assign s_adr = w_gnt1 ? m1_adr : m0_adr;
  assign s_dat = w_gnt1 ? m1_dat : m0_dat;
  assign s_sel = w_gnt1 ? m1_sel : m0_sel;
  assign s_we  = w_gnt1 ? m1_we  : m0_we;
  assign s_cyc = (w_gnt0 & m0_cyc) | (w_gnt1 & m1_cyc);

  assign w_ack_own = s_ack | w_tmo;
  assign w_rdt_own = w_tmo ? DW'(32'hDEAD_BEEF) : s_rdt;

  assign m0_ack = w_gnt0 & w_ack_own;
  assign m1_ack = w_gnt1 & w_ack_own;
  assign m0_rdt = w_gnt0 ? w_rdt_own : '0;
  assign m1_rdt = w_gnt1 ? w_rdt_own : '0;

  assign busy  = w_gnt0 | w_gnt1;
  assign owner = r_owner;

endmodule
